// File: rtl/riscv_pkg.sv
// Shared RISC-V datapath definitions: MemRW encodings, requester ids and
// the dmem arbiter state encoding.
package riscv_pkg;

   typedef enum logic [1:0] {
      MEMRW_RD = 2'b00,
      MEMRW_SW = 2'b01,
      MEMRW_SH = 2'b10,
      MEMRW_SB = 2'b11
   } memrw_e;

   localparam logic REQ_CORE = 1'b0;
   localparam logic REQ_DMA  = 1'b1;

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

endpackage

// File: rtl/dmem_store_align.sv
// Store alignment: turns MemRW, the low address bits and right-aligned store
// data into BRAM byte enables and replicated lane data; flags misaligned stores.
module dmem_store_align
   import riscv_pkg::*;
(
   input  logic [1:0]  memrw,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   output logic [3:0]  we,
   output logic [31:0] din,
   output logic        misalign
);

   always_comb begin
      we       = 4'b0000;
      din      = wdata;
      misalign = 1'b0;
      case (memrw)
         MEMRW_SW: begin
            we       = 4'b1111;
            din      = wdata;
            misalign = (addr_lo != 2'b00);
         end
         MEMRW_SH: begin
            we       = 4'b0011 << {addr_lo[1], 1'b0};
            din      = {2{wdata[15:0]}};
            misalign = addr_lo[0];
         end
         MEMRW_SB: begin
            we  = 4'b0001 << addr_lo;
            din = {4{wdata[7:0]}};
         end
         default: ;
      endcase
      // A misaligned store is dropped: the access still happens, but writes nothing
      if (misalign)
         we = 4'b0000;
   end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Core/DMA arbiter in front of the single-port data BRAM, with DMA lock bursts
// and tagged read return. Define DMEM_ARB_RR_EN for round-robin instead of core priority.
module dmem_port_arbiter
   import riscv_pkg::*;
#(
   parameter int AWIDTH  = 14,
   parameter int MEM_LAT = 1
`ifndef DMEM_ARB_RR_EN
   ,
   parameter int STARVE_MAX = 4
`endif
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              core_req,
   input  logic [1:0]        core_memrw,
   input  logic [31:0]       core_addr,
   input  logic [31:0]       core_wdata,
   output logic              core_gnt,
   output logic              core_rvalid,
   input  logic              dma_req,
   input  logic [1:0]        dma_memrw,
   input  logic [31:0]       dma_addr,
   input  logic [31:0]       dma_wdata,
   input  logic              dma_lock,
   output logic              dma_gnt,
   output logic              dma_rvalid,
   output logic [31:0]       rdata,
   output logic              mem_en,
   output logic [3:0]        mem_we,
   output logic [AWIDTH-1:0] mem_addr,
   output logic [31:0]       mem_din,
   input  logic [31:0]       mem_dout,
   output logic              err_misalign
);

   arb_state_e state, state_next;

`ifdef DMEM_ARB_RR_EN
   logic last_winner;
`else
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
   logic [3:0] starve_cnt;
`endif

   logic [1:0]  sel_memrw;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic [3:0]  align_we;
   logic [31:0] align_din;
   logic        align_misalign;
   logic        rd_issue;
   logic        unused_addr_hi;

   logic [MEM_LAT-1:0] tag_valid;
   logic [MEM_LAT-1:0] tag_id;

   // Grants are decided in the request cycle; nothing is granted while reset is held
   always_comb begin
      core_gnt   = 1'b0;
      dma_gnt    = 1'b0;
      state_next = state;
      if (rst) begin
         case (state)
            ARB: begin
`ifdef DMEM_ARB_RR_EN
               if (core_req && dma_req) begin
                  core_gnt = (last_winner == REQ_DMA);
                  dma_gnt  = (last_winner == REQ_CORE);
               end else begin
                  core_gnt = core_req;
                  dma_gnt  = dma_req;
               end
`else
               if (core_req && !(dma_req && (starve_cnt == STARVE_LIM)))
                  core_gnt = 1'b1;
               else
                  dma_gnt = dma_req;
`endif
               if (dma_gnt && dma_lock)
                  state_next = LOCKED;
            end
            LOCKED: begin
               dma_gnt = dma_req;
               if (dma_gnt && !dma_lock)
                  state_next = ARB;
            end
            default: state_next = ARB;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= ARB;
         err_misalign <= 1'b0;
`ifdef DMEM_ARB_RR_EN
         last_winner  <= REQ_DMA;
`else
         starve_cnt   <= 4'd0;
`endif
      end else begin
         state        <= state_next;
         err_misalign <= mem_en && align_misalign;
`ifdef DMEM_ARB_RR_EN
         if (core_gnt)
            last_winner <= REQ_CORE;
         else if (dma_gnt)
            last_winner <= REQ_DMA;
`else
         // The starvation count is frozen during a lock burst
         if (state == ARB) begin
            if (!dma_req || dma_gnt)
               starve_cnt <= 4'd0;
            else if (starve_cnt != STARVE_LIM)
               starve_cnt <= starve_cnt + 4'd1;
         end
`endif
      end
   end

   assign sel_memrw = dma_gnt ? dma_memrw : core_memrw;
   assign sel_addr  = dma_gnt ? dma_addr  : core_addr;
   assign sel_wdata = dma_gnt ? dma_wdata : core_wdata;

   dmem_store_align u_align (
      .memrw    (sel_memrw),
      .addr_lo  (sel_addr[1:0]),
      .wdata    (sel_wdata),
      .we       (align_we),
      .din      (align_din),
      .misalign (align_misalign)
   );

   assign unused_addr_hi = ^sel_addr[31:AWIDTH+2];

   assign mem_en   = core_gnt | dma_gnt;
   assign mem_we   = mem_en ? align_we : 4'b0000;
   assign mem_din  = mem_en ? align_din : 32'd0;
   assign mem_addr = mem_en ? sel_addr[AWIDTH+1:2] : '0;
   assign rd_issue = mem_en && (sel_memrw == MEMRW_RD);

   // Each granted read travels MEM_LAT stages alongside the BRAM so its data returns to the issuer
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tag_valid <= '0;
         tag_id    <= '0;
      end else begin
         tag_valid[0] <= rd_issue;
         tag_id[0]    <= dma_gnt ? REQ_DMA : REQ_CORE;
         for (int i = 1; i < MEM_LAT; i++) begin
            tag_valid[i] <= tag_valid[i-1];
            tag_id[i]    <= tag_id[i-1];
         end
      end
   end

   assign core_rvalid = tag_valid[MEM_LAT-1] && (tag_id[MEM_LAT-1] == REQ_CORE);
   assign dma_rvalid  = tag_valid[MEM_LAT-1] && (tag_id[MEM_LAT-1] == REQ_DMA);
   assign rdata       = mem_dout;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=2,
// both driven by the same requests. Define DMEM_ARB_RR_EN to check round-robin grants.
module tb_dmem_port_arbiter;
   import riscv_pkg::*;

   logic        clk;
   logic        rst;
   logic        core_req;
   logic [1:0]  core_memrw;
   logic [31:0] core_addr;
   logic [31:0] core_wdata;
   logic        dma_req;
   logic [1:0]  dma_memrw;
   logic [31:0] dma_addr;
   logic [31:0] dma_wdata;
   logic        dma_lock;
   logic [31:0] mem_dout;

   logic        core_gnt, core_rvalid, dma_gnt, dma_rvalid, mem_en, err_misalign;
   logic [31:0] rdata, mem_din;
   logic [3:0]  mem_we;
   logic [13:0] mem_addr;

   logic        core_gnt_b, core_rvalid_b, dma_gnt_b, dma_rvalid_b, mem_en_b, err_misalign_b;
   logic [31:0] rdata_b, mem_din_b;
   logic [3:0]  mem_we_b;
   logic [13:0] mem_addr_b;

   int checkCount = 0;
   int passCount  = 0;

   logic [9:0] gcv;
   logic [9:0] gdv;

   dmem_port_arbiter #(.AWIDTH(14), .MEM_LAT(1)) u_dut (
      .clk(clk), .rst(rst),
      .core_req(core_req), .core_memrw(core_memrw), .core_addr(core_addr),
      .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rvalid(core_rvalid),
      .dma_req(dma_req), .dma_memrw(dma_memrw), .dma_addr(dma_addr),
      .dma_wdata(dma_wdata), .dma_lock(dma_lock), .dma_gnt(dma_gnt),
      .dma_rvalid(dma_rvalid), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
      .err_misalign(err_misalign)
   );

   dmem_port_arbiter #(.AWIDTH(14), .MEM_LAT(2)) u_dut_b (
      .clk(clk), .rst(rst),
      .core_req(core_req), .core_memrw(core_memrw), .core_addr(core_addr),
      .core_wdata(core_wdata), .core_gnt(core_gnt_b), .core_rvalid(core_rvalid_b),
      .dma_req(dma_req), .dma_memrw(dma_memrw), .dma_addr(dma_addr),
      .dma_wdata(dma_wdata), .dma_lock(dma_lock), .dma_gnt(dma_gnt_b),
      .dma_rvalid(dma_rvalid_b), .rdata(rdata_b), .mem_en(mem_en_b), .mem_we(mem_we_b),
      .mem_addr(mem_addr_b), .mem_din(mem_din_b), .mem_dout(mem_dout),
      .err_misalign(err_misalign_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got === exp)
         passCount++;
      else
         $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 time unit later
   task automatic applyStimulus(input logic c_req, input logic [1:0] c_rw,
                                input logic [31:0] c_addr, input logic [31:0] c_wdata,
                                input logic d_req, input logic [1:0] d_rw,
                                input logic [31:0] d_addr, input logic d_lock);
      @(negedge clk);
      core_req   = c_req;
      core_memrw = c_rw;
      core_addr  = c_addr;
      core_wdata = c_wdata;
      dma_req    = d_req;
      dma_memrw  = d_rw;
      dma_addr   = d_addr;
      dma_lock   = d_lock;
      #1;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_outs"}, {21'd0, core_gnt, dma_gnt, mem_en, mem_we, core_rvalid,
                                   dma_rvalid, err_misalign}, 32'd0);
      checkOutput({tag, "_addr"}, 32'(mem_addr), 32'd0);
      checkOutput({tag, "_din"}, mem_din, 32'd0);
      checkOutput({tag, "_outs_b"}, {22'd0, core_gnt_b, dma_gnt_b, mem_en_b, mem_we_b,
                                     core_rvalid_b, dma_rvalid_b}, 32'd0);
   endtask

   initial begin
      rst = 1'b0;
      core_req = 1'b0; core_memrw = MEMRW_RD; core_addr = '0; core_wdata = '0;
      dma_req = 1'b0; dma_memrw = MEMRW_RD; dma_addr = '0; dma_lock = 1'b0;
      dma_wdata = 32'hCAFE_F00D;
      mem_dout = '0;

      // Requests during reset must not be granted
      applyStimulus(1'b1, MEMRW_SW, 32'h10, 32'h1, 1'b1, MEMRW_RD, 32'h20, 1'b0);
      checkAllZero("in_reset");
      @(negedge clk);
      rst = 1'b1;
      applyStimulus(1'b0, MEMRW_RD, 32'h0, 32'h0, 1'b0, MEMRW_RD, 32'h0, 1'b0);
      checkAllZero("after_reset");

      // Both read continuously for six cycles; bit k+2 of gcv/gdv is the grant in cycle k
`ifdef DMEM_ARB_RR_EN
      gcv = 10'b0001010100;
      gdv = 10'b0010101000;
`else
      gcv = 10'b0010111100;
      gdv = 10'b0001000000;
`endif
      for (int i = 0; i < 8; i++) begin
         mem_dout = 32'h1000 + 32'(i);
         applyStimulus(i < 6, MEMRW_RD, 32'h40, 32'h0, i < 6, MEMRW_RD, 32'h80, 1'b0);
         if (i < 6) begin
            checkOutput($sformatf("both_core_gnt_%0d", i), 32'(core_gnt), 32'(gcv[i+2]));
            checkOutput($sformatf("both_dma_gnt_%0d", i), 32'(dma_gnt), 32'(gdv[i+2]));
            checkOutput($sformatf("both_addr_%0d", i), 32'(mem_addr),
                        gdv[i+2] ? 32'h20 : 32'h10);
         end
         checkOutput($sformatf("both_core_rv_%0d", i), 32'(core_rvalid), 32'(gcv[i+1]));
         checkOutput($sformatf("both_dma_rv_%0d", i), 32'(dma_rvalid), 32'(gdv[i+1]));
         checkOutput($sformatf("lat2_core_rv_%0d", i), 32'(core_rvalid_b), 32'(gcv[i]));
         checkOutput($sformatf("lat2_dma_rv_%0d", i), 32'(dma_rvalid_b), 32'(gdv[i]));
         if (gdv[i+1])
            checkOutput($sformatf("dma_rdata_%0d", i), rdata, 32'h1000 + 32'(i));
      end

      // Store lane steering
      applyStimulus(1'b1, MEMRW_SB, 32'h0000_0013, 32'h0000_00AB, 1'b0, MEMRW_RD, 32'h0, 1'b0);
      checkOutput("sb_gnt", {30'd0, core_gnt, dma_gnt}, 32'd2);
      checkOutput("sb_we", 32'(mem_we), 32'b1000);
      checkOutput("sb_din", mem_din, 32'hABAB_ABAB);
      checkOutput("sb_addr", 32'(mem_addr), 32'h004);
      checkOutput("sb_en", 32'(mem_en), 32'd1);

      applyStimulus(1'b1, MEMRW_SH, 32'h0000_0022, 32'h1234_5678, 1'b0, MEMRW_RD, 32'h0, 1'b0);
      checkOutput("sh_we", 32'(mem_we), 32'b1100);
      checkOutput("sh_din", mem_din, 32'h5678_5678);
      checkOutput("sh_addr", 32'(mem_addr), 32'h008);

      applyStimulus(1'b1, MEMRW_SW, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, MEMRW_RD, 32'h0, 1'b0);
      checkOutput("sw_we", 32'(mem_we), 32'b1111);
      checkOutput("sw_din", mem_din, 32'hDEAD_BEEF);

      // Misaligned stores: granted, nothing written, error one cycle later
      applyStimulus(1'b1, MEMRW_SW, 32'h0000_0006, 32'h1111_2222, 1'b0, MEMRW_RD, 32'h0, 1'b0);
      checkOutput("missw_gnt", 32'(core_gnt), 32'd1);
      checkOutput("missw_we", 32'(mem_we), 32'd0);
      checkOutput("missw_err_now", 32'(err_misalign), 32'd0);
      applyStimulus(1'b0, MEMRW_RD, 32'h0, 32'h0, 1'b0, MEMRW_RD, 32'h0, 1'b0);
      checkOutput("missw_err_next", 32'(err_misalign), 32'd1);
      checkOutput("missw_err_next_b", 32'(err_misalign_b), 32'd1);
      applyStimulus(1'b1, MEMRW_SH, 32'h0000_0001, 32'h0000_3333, 1'b0, MEMRW_RD, 32'h0, 1'b0);
      checkOutput("missw_err_clear", 32'(err_misalign), 32'd0);
      checkOutput("missh_we", 32'(mem_we), 32'd0);
      applyStimulus(1'b1, MEMRW_SB, 32'h0000_0003, 32'h0000_005A, 1'b0, MEMRW_RD, 32'h0, 1'b0);
      checkOutput("missh_err_next", 32'(err_misalign), 32'd1);
      checkOutput("sb3_we", 32'(mem_we), 32'b1000);
      applyStimulus(1'b0, MEMRW_RD, 32'h0, 32'h0, 1'b0, MEMRW_RD, 32'h0, 1'b0);
      checkOutput("sb3_no_err", 32'(err_misalign), 32'd0);

      // DMA lock burst holds off the core, including an idle beat inside the burst
      applyStimulus(1'b0, MEMRW_RD, 32'h40, 32'h0, 1'b1, MEMRW_RD, 32'h200, 1'b1);
      checkOutput("lock1_gnt", {30'd0, core_gnt, dma_gnt}, 32'd1);
      applyStimulus(1'b1, MEMRW_RD, 32'h40, 32'h0, 1'b1, MEMRW_SW, 32'h204, 1'b1);
      checkOutput("lock2_gnt", {30'd0, core_gnt, dma_gnt}, 32'd1);
      checkOutput("lock2_we", 32'(mem_we), 32'b1111);
      checkOutput("lock2_din", mem_din, 32'hCAFE_F00D);
      checkOutput("lock2_addr", 32'(mem_addr), 32'h081);
      applyStimulus(1'b1, MEMRW_RD, 32'h40, 32'h0, 1'b0, MEMRW_RD, 32'h0, 1'b1);
      checkOutput("lock_idle", {30'd0, core_gnt, mem_en}, 32'd0);
      applyStimulus(1'b1, MEMRW_RD, 32'h40, 32'h0, 1'b1, MEMRW_RD, 32'h208, 1'b0);
      checkOutput("lock3_gnt", {30'd0, core_gnt, dma_gnt}, 32'd1);
      applyStimulus(1'b1, MEMRW_RD, 32'h40, 32'h0, 1'b0, MEMRW_RD, 32'h0, 1'b0);
      checkOutput("unlock_core", {30'd0, core_gnt, dma_gnt}, 32'd2);

      // Reset one cycle after a core read at MEM_LAT=2 discards the return
      applyStimulus(1'b1, MEMRW_RD, 32'h300, 32'h0, 1'b0, MEMRW_RD, 32'h0, 1'b0);
      checkOutput("rstrd_gnt_b", 32'(core_gnt_b), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      core_req = 1'b0;
      #1;
      checkOutput("rstrd_rv_0", 32'(core_rvalid_b), 32'd0);
      for (int i = 1; i < 3; i++) begin
         @(negedge clk);
         #1;
         checkOutput($sformatf("rstrd_rv_%0d", i), 32'(core_rvalid_b), 32'd0);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkAllZero("rstrd_release");
      applyStimulus(1'b0, MEMRW_RD, 32'h0, 32'h0, 1'b0, MEMRW_RD, 32'h0, 1'b0);
      checkAllZero("rstrd_after");

      // Reset from LOCKED returns to ARB, so a lone core request is granted
      applyStimulus(1'b0, MEMRW_RD, 32'h0, 32'h0, 1'b1, MEMRW_RD, 32'h400, 1'b1);
      checkOutput("rstlock_dma_gnt", 32'(dma_gnt), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      dma_req = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      applyStimulus(1'b1, MEMRW_RD, 32'h44, 32'h0, 1'b0, MEMRW_RD, 32'h0, 1'b0);
      checkOutput("rstlock_core_gnt", {30'd0, core_gnt, dma_gnt}, 32'd2);

      applyStimulus(1'b0, MEMRW_RD, 32'h0, 32'h0, 1'b0, MEMRW_RD, 32'h0, 1'b0);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
